// File: rtl/pipe_sink.sv
// Credit-based receive buffer for a fixed-latency, no-stall pipe: grants launch credits only while
// every outstanding result is guaranteed a slot, then presents results in order to a valid/ready sink.
module pipe_sink #(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 1,
    parameter int DEPTH   = LATENCY + 2
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    output logic                       issue_ready_out,
    input  logic                       issue_valid_in,
    input  logic                       pipe_valid_in,
    input  logic [WIDTH-1:0]           pipe_data_in,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       error_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] ONE_PTR   = PW'(1);

    if (LATENCY < 1 || DEPTH < 1) begin : g_param_check
        $error("pipe_sink: LATENCY and DEPTH must both be at least 1");
    end

    logic [CW-1:0]    inflight_q, inflight_d;
    logic [CW-1:0]    occ_q, occ_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic issue, arrive, full, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ONE_PTR;
    endfunction

    // Credits count both buffered and in-flight items, so an arrival can never find the buffer full.
    assign issue_ready_out = rst_n_in && (({1'b0, inflight_q} + {1'b0, occ_q}) < DEPTH_SUM);

    assign valid_out = (occ_q != '0);
    assign data_out  = mem_q[rd_ptr_q];
    assign count_out = occ_q;
    assign error_out = err_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        issue      = issue_valid_in && issue_ready_out;
        arrive     = pipe_valid_in && (inflight_q != '0);
        full       = (occ_q == DEPTH_CNT);
        push       = arrive && !full;
        pop        = valid_out && ready_in;
        inflight_d = inflight_q;
        occ_d      = occ_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        err_d      = err_q;

        if (issue && !arrive) begin
            inflight_d = inflight_q + ONE_CNT;
        end else if (arrive && !issue) begin
            inflight_d = inflight_q - ONE_CNT;
        end

        if (push && !pop) begin
            occ_d = occ_q + ONE_CNT;
        end else if (pop && !push) begin
            occ_d = occ_q - ONE_CNT;
        end

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        // Rejected launches, orphan arrivals and overflow all latch the sticky flag.
        if ((issue_valid_in && !issue_ready_out) ||
            (pipe_valid_in && (inflight_q == '0)) ||
            (arrive && full)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            inflight_q <= '0;
            occ_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            err_q      <= err_d;
        end
    end

    // NOTE: storage is deliberately not reset; valid_out masks its contents until written.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pipe_data_in;
        end
    end

endmodule
